rle_stream_arbiter: RTL
=======================

# rle_stream_arbiter

Round-robin, frame-granular arbiter that shares one run-length encoder datapath between two byte-stream requesters. It owns the encoder for a whole frame, forwards the granted requester's bytes with zero latency, and enforces a maximum frame length by truncating and discarding overlong frames. It waits for the encoder's end-of-frame completion before it regrants. It sits directly in front of the RLE encoder's input port.

## Interface
- MAX_LEN, 255: maximum bytes forwarded per frame (≥1). The length counter is $clog2(MAX_LEN+1) bits wide.

- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- req0_in  in  out_st  requester 0 byte (data[7:0]) and valid
- req0_last  in  1  marks the final byte of a requester 0 frame
- req0_ready  out  1  requester 0 byte accepted when valid && ready
- req1_in, req1_last, req1_ready  same as requester 0, for requester 1
- enc_in  out  out_st  byte and valid to the encoder
- enc_last  out  1  final byte of the frame to the encoder
- enc_ready  in  1  encoder accepts a byte this cycle
- enc_done  in  1  single-cycle pulse; encoder has emitted the final run of the frame
- grant_id  out  1  requester currently owning the encoder
- busy  out  1  high in every state except IDLE
- overflow  out  1  registered single-cycle pulse when a frame is truncated

## Operation
- The FSM has five states: IDLE, GRANT0, GRANT1, DISCARD, DRAIN. A round-robin pointer rr names the preferred requester.
- IDLE:
  - Both reqN_ready = 0 and enc_in.valid = 0.
  - If reqN_in.valid is high for one or more requesters, pick requester rr if it is valid, otherwise the other one.
  - Register grant_id and clear len.
  - Go to GRANTn on the next cycle.
- GRANTn:
  - enc_in = reqn_in, combinationally.
  - reqn_ready = enc_ready. The other requester's ready = 0.
  - A transfer occurs when reqn_in.valid && enc_ready. Each transfer increments len.
  - enc_last = reqn_last || (len == MAX_LEN-1), qualified by valid.
- When the last byte transfers and reqn_last is high: go to DRAIN.
- When the last byte transfers because of the length limit and reqn_last is low:
  - Pulse overflow on the next cycle.
  - Go to DISCARD.
- DISCARD:
  - reqn_ready = 1 and enc_in.valid = 0. Requester bytes are dropped.
  - Go to DRAIN after a transfer with reqn_last = 1.
- DRAIN:
  - No readies are asserted.
  - Exit to IDLE on enc_done or on done_seen. On exit, toggle rr to the requester that was not granted.
- done_seen is set by enc_done while in DISCARD and cleared on entry to IDLE.
- enc_done in IDLE or GRANTn is a protocol violation and is ignored.
- MAX_LEN = 1: every forwarded byte carries enc_last. A single-byte frame with req_last high produces no overflow.

## Timing
- Reset values: state IDLE, rr 0, len 0, grant_id 0, busy 0, overflow 0, done_seen 0, all reqN_ready 0, enc_in 0 (valid 0), enc_last 0.
- Reset takes effect asynchronously. A frame in flight is abandoned with no flush.
- Grant latency: 1 cycle from request valid in IDLE to ready in GRANTn.
- The data path is combinational, with 0-cycle latency.
- busy rises with the IDLE→GRANT transition and falls on the DRAIN→IDLE transition.
- Minimum gap between frames: enc_done at cycle t, IDLE at t+1, next GRANT at t+2.
- A requester's valid may rise and fall freely while it is not granted. Data must be held stable while valid && !ready.

## Structure
- Shared package FSMpackage:
  - keeps out_st.
  - adds typedef enum arb_state {IDLE, GRANT0, GRANT1, DISCARD, DRAIN}.
- Single module with no sub-module. A 2-input round-robin pick is small enough to inline as a function.

## Test plan
- Requester 0 only, bytes AA AA BB with last on BB, enc_ready = 1:
  - enc_in carries AA, AA, BB with enc_last on BB and grant_id = 0.
  - After the enc_done pulse, the FSM is in IDLE and rr = 1.
- Both requesters valid in the first cycle after reset:
  - Requester 0's frame is forwarded completely first.
  - Requester 1 is granted 2 cycles after enc_done.
- Requester 1 sends 11 22 33, with enc_ready low for 3 cycles mid-frame:
  - req1_ready tracks enc_ready.
  - No byte is lost or duplicated.
  - req0_ready stays 0.
- MAX_LEN = 4, requester 1 sends 6 bytes 01..06 with last on 06:
  - 01..04 are forwarded, with enc_last on 04.
  - overflow pulses once.
  - 05 and 06 are consumed and dropped, then the FSM enters DRAIN.
- Same truncated frame, with enc_done arriving during DISCARD:
  - done_seen is set.
  - DRAIN exits to IDLE one cycle after entry.
- reset asserted mid-frame in GRANT1:
  - All outputs return to their reset values immediately.
  - The next grant goes to requester 0.

Source files
------------

// File: rtl/rle_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : FSMpackage
// Description : Shared types for the RLE stream arbiter: the byte/valid
//               stream beat and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package FSMpackage;

  // One stream beat: a byte plus its valid qualifier
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } out_st;

  // Arbiter states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT0  = 3'd1,
    GRANT1  = 3'd2,
    DISCARD = 3'd3,
    DRAIN   = 3'd4
  } arb_state;

endpackage : FSMpackage
`default_nettype wire

// File: rtl/rle_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rle_stream_arbiter
// Description : Frame-granular round-robin arbiter sharing one RLE encoder
//               between two byte-stream requesters. Forwards the granted
//               stream with zero latency, truncates frames longer than
//               MAX_LEN (dropping the tail), and waits for the encoder's
//               end-of-frame pulse before regranting.
// Revision    : 1.0 - initial release
// ============================================================================
module rle_stream_arbiter
  import FSMpackage::*;
#(
  parameter int MAX_LEN = 255
) (
  input  logic  clk,
  input  logic  reset,
  input  out_st req0_in,
  input  logic  req0_last,
  output logic  req0_ready,
  input  out_st req1_in,
  input  logic  req1_last,
  output logic  req1_ready,
  output out_st enc_in,
  output logic  enc_last,
  input  logic  enc_ready,
  input  logic  enc_done,
  output logic  grant_id,
  output logic  busy,
  output logic  overflow
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] c_len_lim = LW'(MAX_LEN - 1);

  arb_state      r_state;
  logic          r_rr;
  logic [LW-1:0] r_len;
  logic          r_grant_id;
  logic          r_busy;
  logic          r_overflow;
  logic          r_done_seen;

  out_st         w_cur_in;
  logic          w_cur_last;
  logic          w_cur_ready;
  logic          w_xfer;
  logic          w_at_lim;
  logic          w_pick;

  // Round-robin choice between two requesters: preferred one wins if valid
  function automatic logic rr_pick(input logic pref, input logic v0, input logic v1);
    logic sel;
    if (pref) sel = v1 ? 1'b1 : 1'b0;
    else      sel = v0 ? 1'b0 : 1'b1;
    return sel;
  endfunction

  assign w_pick     = rr_pick(r_rr, req0_in.valid, req1_in.valid);
  assign w_cur_in   = r_grant_id ? req1_in   : req0_in;
  assign w_cur_last = r_grant_id ? req1_last : req0_last;
  assign w_at_lim   = (r_len == c_len_lim);
  assign w_cur_ready = r_grant_id ? req1_ready : req0_ready;
  assign w_xfer     = w_cur_in.valid && w_cur_ready;

  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign overflow = r_overflow;

  // Zero-latency datapath and ready steering for the owning requester
  always_comb begin
    enc_in     = '0;
    enc_last   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      GRANT0: begin
        enc_in     = req0_in;
        enc_last   = req0_in.valid && (req0_last || w_at_lim);
        req0_ready = enc_ready;
      end
      GRANT1: begin
        enc_in     = req1_in;
        enc_last   = req1_in.valid && (req1_last || w_at_lim);
        req1_ready = enc_ready;
      end
      DISCARD: begin
        // Tail of a truncated frame is swallowed without reaching the encoder
        if (r_grant_id) req1_ready = 1'b1;
        else            req0_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Frame-ownership FSM with registered grant, busy and overflow outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr        <= 1'b0;
      r_len       <= '0;
      r_grant_id  <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      case (r_state)
        IDLE: begin
          // enc_done here is a protocol violation and is ignored
          if (req0_in.valid || req1_in.valid) begin
            r_grant_id <= w_pick;
            r_len      <= '0;
            r_busy     <= 1'b1;
            r_state    <= w_pick ? GRANT1 : GRANT0;
          end
        end
        GRANT0, GRANT1: begin
          if (w_xfer) begin
            r_len <= r_len + LW'(1);
            if (w_cur_last) begin
              r_state <= DRAIN;
            end else if (w_at_lim) begin
              r_overflow <= 1'b1;
              r_state    <= DISCARD;
            end
          end
        end
        DISCARD: begin
          // The encoder may finish the truncated frame before the tail ends
          if (enc_done) r_done_seen <= 1'b1;
          if (w_xfer && w_cur_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (enc_done || r_done_seen) begin
            r_state     <= IDLE;
            r_rr        <= ~r_grant_id;
            r_done_seen <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : rle_stream_arbiter
`default_nettype wire
